trng_sequencer: RTL and testbench
=================================

# trng_sequencer

Run controller for the TRNG entropy path. On a start request it loads the LFSR seed and polynomial, and for each output bit XOR-folds the synchronised ring-oscillator sample over a programmable time window. It whitens each folded bit with the LFSR MSB and shifts the result into an output word. It sits between the register map, which supplies configuration, start and acknowledge, and the ring-oscillator synchroniser. It also feeds live LFSR and window-counter values back for readback.

## Interface
- lfsr_width, 12, width of LFSR, polynomial, seed and output word (≥2)
- tmw_width, 12, width of time-window counter and tmw_max
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle run request
- abort  in  1  cancel current run
- lfsr_seed  in  lfsr_width  initial LFSR state
- lfsr_poly  in  lfsr_width  feedback tap mask
- tmw_max  in  tmw_width  window length minus one, in cycles per bit
- ro_in  in  1  ring-oscillator bit, already synchronised to clk
- rd_ack  in  1  consumer has taken rnd_data
- busy  out  1  high in LOAD/SAMPLE/DONE
- rnd_data  out  lfsr_width  last completed random word
- rnd_valid  out  1  rnd_data unread
- lfsr_o  out  lfsr_width  current LFSR state
- tmw_o  out  tmw_width  current window counter

## Operation
- State machine states:
  - IDLE: accepts start only when rnd_valid=0; otherwise start is dropped silently. Goes to LOAD.
  - LOAD (1 cycle): latch lfsr_poly and tmw_max into internal copies; lfsr ← lfsr_seed, or 1 if lfsr_seed=0 (lock-up guard); tmw ← 0; acc ← 0; bitcnt ← 0; shift reg ← 0. Goes to SAMPLE.
  - SAMPLE, every cycle:
    - If tmw ≠ tmw_max: acc ← acc ^ ro_in; tmw ← tmw+1.
    - If tmw = tmw_max (bit boundary):
      - bit = acc ^ ro_in ^ lfsr[W-1]
      - shift ← {shift[W-2:0], bit}
      - lfsr ← {lfsr[W-2:0], ^(lfsr & poly)}
      - tmw ← 0; acc ← 0; bitcnt ← bitcnt+1
      - If bitcnt = W-1 at the boundary: go to DONE.
  - DONE (1 cycle): rnd_data ← shift; rnd_valid ← 1. Goes to IDLE.
- rnd_valid clears on the edge after rd_ack=1 while rnd_valid=1. rnd_data holds its value until the next DONE. rd_ack while rnd_valid=0 is ignored.
- abort in LOAD/SAMPLE/DONE: go to IDLE on the next edge. No rnd_valid is set, rnd_data is unchanged, and the partial word is discarded. abort in IDLE has no effect.
- Simultaneous abort and last bit boundary, or abort in DONE: abort wins, no valid.
- Changes to lfsr_poly or tmw_max during a run are ignored, because the latched copies are used. lfsr_seed is read only in LOAD.
- lfsr_o and tmw_o expose the live registers and hold their values in IDLE.
- tmw_max=0 means one sample per bit. The counter never wraps past tmw_max.

## Timing
- Reset values: state IDLE, busy 0, rnd_valid 0, rnd_data 0, lfsr_o 0, tmw_o 0; internal acc, bitcnt, shift 0.
- Run timeline, with start sampled at edge E0:
  - LOAD after E0.
  - SAMPLE after E1.
  - Each bit takes tmw_max+1 SAMPLE cycles.
  - DONE after edge E(1+W·(tmw_max+1)).
  - rnd_valid=1 and busy=0 after edge E(2+W·(tmw_max+1)).
- busy rises the edge after start is accepted and falls with rnd_valid rising.
- A start in the same cycle as rd_ack with rnd_valid=1 is dropped. The initiator retries after rnd_valid=0.
- Reset mid-run returns all state to reset values immediately and asynchronously.

## Test plan
- W=12, tmw_max=0, ro_in=0, seed 'h800, poly 'h800 (rotate) -> rnd_valid 14 edges after start, rnd_data='h800, lfsr_o='h800.
- Same as above with ro_in=1 constant -> rnd_data='h7FF. With tmw_max=1 and ro_in=1 -> rnd_data='h800 at 26 edges (parity fold).
- seed 'h000, poly 'h800, ro_in=0, tmw_max=0 -> lfsr loaded as 'h001, rnd_data='h001.
- tmw_max=3, abort at the 20th SAMPLE cycle -> busy=0 the next edge, rnd_valid stays 0, rnd_data unchanged; a new start then completes normally at 50 edges.
- Complete a run, then pulse start with rnd_valid=1 and no rd_ack -> ignored (busy stays 0). Assert rd_ack -> rnd_valid=0 the next edge; start then accepted.
- Change tmw_max and lfsr_poly mid-run -> result and latency match the values latched at LOAD. Deassert rst mid-SAMPLE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/trng_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : trng_seq_if
// Description : Register-map / TRNG sequencer bundle: configuration, run
//               control, result handshake and live-register readback.
// Revision    : 1.0 - initial release
// ============================================================================
interface trng_seq_if #(
    parameter int LFSR_WIDTH = 12,
    parameter int TMW_WIDTH  = 12
);
    logic                  start;
    logic                  abort;
    logic [LFSR_WIDTH-1:0] lfsr_seed;
    logic [LFSR_WIDTH-1:0] lfsr_poly;
    logic [TMW_WIDTH-1:0]  tmw_max;
    logic                  ro_in;
    logic                  rd_ack;
    logic                  busy;
    logic [LFSR_WIDTH-1:0] rnd_data;
    logic                  rnd_valid;
    logic [LFSR_WIDTH-1:0] lfsr_o;
    logic [TMW_WIDTH-1:0]  tmw_o;

    modport master (
        output start, abort, lfsr_seed, lfsr_poly, tmw_max, ro_in, rd_ack,
        input  busy, rnd_data, rnd_valid, lfsr_o, tmw_o
    );

    modport slave (
        input  start, abort, lfsr_seed, lfsr_poly, tmw_max, ro_in, rd_ack,
        output busy, rnd_data, rnd_valid, lfsr_o, tmw_o
    );
endinterface
`default_nettype wire

// File: rtl/trng_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trng_sequencer
// Description : TRNG run controller - folds ring-oscillator samples over a
//               time window, whitens with an LFSR and assembles output words.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_sequencer #(
    parameter int LFSR_WIDTH = 12,
    parameter int TMW_WIDTH  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    trng_seq_if.slave  bus
);
    localparam int                    c_CNT_W    = (LFSR_WIDTH > 2) ? $clog2(LFSR_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0]    c_BIT_LAST = c_CNT_W'(LFSR_WIDTH - 1);
    localparam logic [LFSR_WIDTH-1:0] c_LFSR_ONE = LFSR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [LFSR_WIDTH-1:0] r_poly;
    logic [LFSR_WIDTH-1:0] r_shift;
    logic [LFSR_WIDTH-1:0] r_rnd_data;
    logic                  r_rnd_valid;
    logic [TMW_WIDTH-1:0]  r_tmw;
    logic [TMW_WIDTH-1:0]  r_tmw_max;
    logic                  r_acc;
    logic [c_CNT_W-1:0]    r_bitcnt;

    logic                  w_boundary;
    logic                  w_bit;
    logic                  w_fb;

    assign w_boundary = (r_tmw == r_tmw_max);
    assign w_bit      = r_acc ^ bus.ro_in ^ r_lfsr[LFSR_WIDTH-1];
    assign w_fb       = ^(r_lfsr & r_poly);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // A pending unread word blocks new runs.
                if (bus.start && !r_rnd_valid) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_next = bus.abort ? ST_IDLE : ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_boundary && (r_bitcnt == c_BIT_LAST)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= '0;
            r_poly      <= '0;
            r_shift     <= '0;
            r_rnd_data  <= '0;
            r_rnd_valid <= 1'b0;
            r_tmw       <= '0;
            r_tmw_max   <= '0;
            r_acc       <= 1'b0;
            r_bitcnt    <= '0;
        end else begin
            if (bus.rd_ack && r_rnd_valid) begin
                r_rnd_valid <= 1'b0;
            end
            case (r_state)
                ST_LOAD: begin
                    if (!bus.abort) begin
                        r_poly    <= bus.lfsr_poly;
                        r_tmw_max <= bus.tmw_max;
                        // An all-zero seed would lock the LFSR permanently.
                        r_lfsr    <= (bus.lfsr_seed == '0) ? c_LFSR_ONE : bus.lfsr_seed;
                        r_tmw     <= '0;
                        r_acc     <= 1'b0;
                        r_bitcnt  <= '0;
                        r_shift   <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (!bus.abort) begin
                        if (w_boundary) begin
                            r_shift  <= {r_shift[LFSR_WIDTH-2:0], w_bit};
                            r_lfsr   <= {r_lfsr[LFSR_WIDTH-2:0], w_fb};
                            r_tmw    <= '0;
                            r_acc    <= 1'b0;
                            r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                        end else begin
                            r_acc <= r_acc ^ bus.ro_in;
                            r_tmw <= r_tmw + TMW_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.abort) begin
                        r_rnd_data  <= r_shift;
                        r_rnd_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rnd_data  = r_rnd_data;
    assign bus.rnd_valid = r_rnd_valid;
    assign bus.lfsr_o    = r_lfsr;
    assign bus.tmw_o     = r_tmw;
endmodule
`default_nettype wire

// File: tb/tb_trng_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trng_sequencer
// Description : Directed self-checking bench for trng_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_sequencer;
    localparam int c_W = 12;
    localparam int c_T = 12;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n;

    trng_seq_if #(.LFSR_WIDTH(c_W), .TMW_WIDTH(c_T)) bus ();

    trng_sequencer #(.LFSR_WIDTH(c_W), .TMW_WIDTH(c_T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [11:0] seed, input logic [11:0] poly,
                             input logic [11:0] tmax, input logic ro);
        bus.lfsr_seed = seed;
        bus.lfsr_poly = poly;
        bus.tmw_max   = tmax;
        bus.ro_in     = ro;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!bus.rnd_valid && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic ack(input string tag);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        check(tag, 32'(bus.rnd_valid), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.lfsr_seed = '0;
        bus.lfsr_poly = '0;
        bus.tmw_max   = '0;
        bus.ro_in     = 1'b0;
        bus.rd_ack    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_busy",   32'(bus.busy),      32'd0);
        check("rst_valid",  32'(bus.rnd_valid), 32'd0);
        check("rst_data",   32'(bus.rnd_data),  32'd0);
        check("rst_lfsr",   32'(bus.lfsr_o),    32'd0);
        check("rst_tmw",    32'(bus.tmw_o),     32'd0);

        // Rotate polynomial, ro_in=0: the word is the LFSR MSB sequence.
        start_run(12'h800, 12'h800, 12'd0, 1'b0);
        check("a_busy_rise", 32'(bus.busy), 32'd1);
        wait_valid(n);
        check("a_latency", 32'(n), 32'd14);
        check("a_data",    32'(bus.rnd_data), 32'h800);
        check("a_lfsr",    32'(bus.lfsr_o),   32'h800);
        check("a_busy_fall", 32'(bus.busy), 32'd0);
        ack("a_ack");

        start_run(12'h800, 12'h800, 12'd0, 1'b1);
        wait_valid(n);
        check("b_latency", 32'(n), 32'd14);
        check("b_data",    32'(bus.rnd_data), 32'h7FF);
        ack("b_ack");

        // Two ones per window fold to zero.
        start_run(12'h800, 12'h800, 12'd1, 1'b1);
        wait_valid(n);
        check("c_latency", 32'(n), 32'd26);
        check("c_data",    32'(bus.rnd_data), 32'h800);
        ack("c_ack");

        start_run(12'h000, 12'h800, 12'd0, 1'b0);
        tick();
        check("d_lfsr_load", 32'(bus.lfsr_o), 32'h001);
        wait_valid(n);
        check("d_latency", 32'(n + 1), 32'd14);
        check("d_data",    32'(bus.rnd_data), 32'h001);

        // Start with an unread word pending is dropped.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("e_start_drop_busy",  32'(bus.busy),      32'd0);
        tick();
        check("e_start_drop_busy2", 32'(bus.busy),      32'd0);
        check("e_valid_hold",       32'(bus.rnd_valid), 32'd1);
        ack("e_ack");

        // Abort during the 20th SAMPLE cycle.
        start_run(12'h800, 12'h800, 12'd3, 1'b0);
        repeat (20) tick();
        check("f_busy_pre_abort", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("f_abort_busy",  32'(bus.busy),      32'd0);
        check("f_abort_valid", 32'(bus.rnd_valid), 32'd0);
        check("f_abort_data",  32'(bus.rnd_data),  32'h001);
        repeat (3) tick();
        check("f_abort_valid_late", 32'(bus.rnd_valid), 32'd0);
        check("f_abort_idle",       32'(bus.busy),      32'd0);

        start_run(12'h800, 12'h800, 12'd3, 1'b0);
        wait_valid(n);
        check("g_latency", 32'(n), 32'd50);
        check("g_data",    32'(bus.rnd_data), 32'h800);
        ack("g_ack");

        // Configuration changes after LOAD must not affect the run.
        start_run(12'h800, 12'h800, 12'd1, 1'b1);
        tick();
        bus.tmw_max   = 12'd0;
        bus.lfsr_poly = 12'h000;
        wait_valid(n);
        check("h_latency", 32'(n + 1), 32'd26);
        check("h_data",    32'(bus.rnd_data), 32'h800);
        check("h_lfsr",    32'(bus.lfsr_o),   32'h800);
        ack("h_ack");

        // Asynchronous reset in the middle of SAMPLE.
        start_run(12'h800, 12'h800, 12'd3, 1'b0);
        repeat (6) tick();
        check("i_tmw_nonzero", 32'(bus.tmw_o != 0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("i_rst_busy",  32'(bus.busy),      32'd0);
        check("i_rst_valid", 32'(bus.rnd_valid), 32'd0);
        check("i_rst_data",  32'(bus.rnd_data),  32'd0);
        check("i_rst_lfsr",  32'(bus.lfsr_o),    32'd0);
        check("i_rst_tmw",   32'(bus.tmw_o),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
